cnn_pixel_streamer: RTL and testbench

//  Frame source for the CNN core. Host loads one 28x28 8-bit image into a local frame buffer.
//  On start, the block:
//   - pulses the core reset;
//   - streams the pixels to the core's data_in, one per cycle;
//   - waits for the core's finish and latches its 4-bit decision for the host.

---
 rtl/cnn_stream_pkg.sv | 19 +
 rtl/cnn_pixel_streamer_if.sv | 34 +++
 rtl/pixel_frame_ram.sv | 28 ++
 rtl/cnn_pixel_streamer.sv | 140 ++++++++++++++
 tb/tb_cnn_pixel_streamer.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/cnn_stream_pkg.sv
// Shared constants and FSM state encoding for the CNN pixel streamer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cnn_stream_pkg;
  localparam int NUM_PIXELS  = 784;
  localparam int DATA_W      = 8;
  localparam int ADDR_W      = 10;
  localparam int RES_W       = 4;
  localparam int DEF_TIMEOUT = 1048576;

  localparam logic [RES_W-1:0] ERR_DECISION = 4'hF;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CORE_RST = 2'd1,
    STREAM   = 2'd2,
    WAIT     = 2'd3
  } state_t;
endpackage

// File: rtl/cnn_pixel_streamer_if.sv
// Host-side and core-side signal bundle of the pixel streamer.
// Latency: n/a (wires only).
// Backpressure: none; the core takes one pixel per cycle unconditionally.
interface cnn_pixel_streamer_if;
  import cnn_stream_pkg::*;

  // host frame-buffer write port and run control
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              start;
  logic              ack;
  logic              busy;
  logic [RES_W-1:0]  result;
  logic              result_valid;
  logic              timeout_err;

  // CNN core side
  logic              core_rst_n;
  logic [DATA_W-1:0] pix_data;
  logic              pix_valid;
  logic              core_finish;
  logic [RES_W-1:0]  core_decision;

  modport slave (
    input  wr_en, wr_addr, wr_data, start, ack, core_finish, core_decision,
    output busy, result, result_valid, timeout_err, core_rst_n, pix_data, pix_valid
  );

  modport master (
    output wr_en, wr_addr, wr_data, start, ack, core_finish, core_decision,
    input  busy, result, result_valid, timeout_err, core_rst_n, pix_data, pix_valid
  );
endinterface

// File: rtl/pixel_frame_ram.sv
// Single-frame pixel store: one write port, one synchronous read port, no reset.
// Latency: read data valid one cycle after rd_en.
// Backpressure: none; caller guarantees addresses are in range.
module pixel_frame_ram #(
  parameter int DEPTH  = 784,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);
  logic [DATA_W-1:0] mem [DEPTH];

  // host write port
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // registered read port
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/cnn_pixel_streamer.sv
// Frame source for the CNN core: resets the core, streams a buffered frame, latches the decision.
// Latency: first pixel two edges after the start edge, then one pixel per cycle.
// Backpressure: none toward the core; host start/writes are ignored while busy.
module cnn_pixel_streamer
  import cnn_stream_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input logic                 clk,
  input logic                 rst_n,
  cnn_pixel_streamer_if.slave bus
);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int CW = ADDR_W + 1;

  state_t            state, state_nxt;
  logic [CW-1:0]     rd_cnt;
  logic              rd_vld;
  logic [TW-1:0]     tmo_cnt;
  logic              rd_en;
  logic              wr_ok;
  logic [DATA_W-1:0] ram_q;
  logic              run_go, fin_hit, tmo_hit;

  logic              busy_q, core_rst_q, pix_valid_q, result_valid_q, timeout_err_q;
  logic [DATA_W-1:0] pix_data_q;
  logic [RES_W-1:0]  result_q;

  // Writes only while idle; the busy register is still low on the start edge itself.
  assign wr_ok = bus.wr_en && !busy_q && (bus.wr_addr < ADDR_W'(NUM_PIXELS));
  // The read for pixel 0 goes out during CORE_RST so the first pixel lands right after.
  assign rd_en = ((state == CORE_RST) || (state == STREAM)) && (rd_cnt < CW'(NUM_PIXELS));

  pixel_frame_ram #(
    .DEPTH  (NUM_PIXELS),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_ok),
    .wr_addr (bus.wr_addr),
    .wr_data (bus.wr_data),
    .rd_en   (rd_en),
    .rd_addr (rd_cnt[ADDR_W-1:0]),
    .rd_data (ram_q)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next state and per-cycle event strobes
  always_comb begin
    state_nxt = state;
    run_go    = 1'b0;
    fin_hit   = 1'b0;
    tmo_hit   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = CORE_RST;
          run_go    = 1'b1;
        end
      end
      CORE_RST: state_nxt = STREAM;
      STREAM: begin
        // all reads issued and the last one already handed to the output stage
        if ((rd_cnt == CW'(NUM_PIXELS)) && !rd_vld) state_nxt = WAIT;
      end
      WAIT: begin
        // finish has priority over a same-cycle expiry
        if (bus.core_finish) begin
          fin_hit   = 1'b1;
          state_nxt = IDLE;
        end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
          tmo_hit   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: read counter, pixel pipeline, timeout counter, host-visible status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt         <= '0;
      rd_vld         <= 1'b0;
      tmo_cnt        <= '0;
      busy_q         <= 1'b0;
      core_rst_q     <= 1'b0;
      pix_data_q     <= '0;
      pix_valid_q    <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      timeout_err_q  <= 1'b0;
    end else begin
      core_rst_q  <= !run_go;
      rd_vld      <= rd_en;
      pix_valid_q <= rd_vld;
      pix_data_q  <= rd_vld ? ram_q : '0;

      if (rd_en)              rd_cnt <= rd_cnt + 1'b1;
      else if (state == IDLE) rd_cnt <= '0;

      if (state == WAIT) tmo_cnt <= tmo_cnt + 1'b1;
      else               tmo_cnt <= '0;

      if (run_go) begin
        busy_q         <= 1'b1;
        result_valid_q <= 1'b0;
        timeout_err_q  <= 1'b0;
      end else if ((state == IDLE) && bus.ack) begin
        result_valid_q <= 1'b0;
        timeout_err_q  <= 1'b0;
      end

      if (fin_hit) begin
        result_q       <= bus.core_decision;
        result_valid_q <= 1'b1;
        busy_q         <= 1'b0;
      end else if (tmo_hit) begin
        result_q       <= ERR_DECISION;
        timeout_err_q  <= 1'b1;
        result_valid_q <= 1'b1;
        busy_q         <= 1'b0;
      end
    end
  end

  assign bus.busy         = busy_q;
  assign bus.core_rst_n   = core_rst_q;
  assign bus.pix_data     = pix_data_q;
  assign bus.pix_valid    = pix_valid_q;
  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;
  assign bus.timeout_err  = timeout_err_q;
endmodule

// File: tb/tb_cnn_pixel_streamer.sv
// Scoreboard bench for cnn_pixel_streamer: frame model and expected queues vs. DUT outputs.
// Latency: checks exact start/stream/timeout cycle positions.
// Backpressure: n/a; noise writes, finish and ack pulses are injected while busy.
module tb_cnn_pixel_streamer;
  localparam int NPIX = 784;
  localparam int TMO  = 64;

  logic clk;
  logic rst_n;
  cnn_pixel_streamer_if bus();

  cnn_pixel_streamer #(.TIMEOUT(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] model_mem [NPIX];
  logic [7:0] exp_pix [$];
  logic [4:0] exp_res [$];   // {timeout_err, result}

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // monitor: pixel stream and result events against the expected queues
  initial begin
    logic prev_rv;
    logic [7:0] ep;
    logic [4:0] er;
    prev_rv = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.pix_valid) begin
        if (exp_pix.size() == 0) chk("extra_pixel", 32'(bus.pix_data), 32'hFFFF_FFFF);
        else begin
          ep = exp_pix.pop_front();
          chk("pix_data", 32'(bus.pix_data), 32'(ep));
        end
      end
      if (bus.result_valid && !prev_rv) begin
        if (exp_res.size() == 0) chk("extra_result", 32'({bus.timeout_err, bus.result}), 32'hFFFF_FFFF);
        else begin
          er = exp_res.pop_front();
          chk("result", 32'({bus.timeout_err, bus.result}), 32'(er));
        end
      end
      prev_rv = bus.result_valid;
    end
  end

  task automatic load(input bit incr);
    logic [7:0] d;
    for (int i = 0; i < NPIX; i++) begin
      @(negedge clk);
      d = incr ? 8'(i) : 8'($urandom);
      bus.wr_en = 1'b1; bus.wr_addr = 10'(i); bus.wr_data = d;
      model_mem[i] = d;
    end
    repeat (4) begin
      @(negedge clk);
      bus.wr_addr = 10'($urandom_range(NPIX, 1023)); bus.wr_data = 8'($urandom);
    end
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic do_ack();
    @(negedge clk);
    bus.ack = 1'b1;
    @(posedge clk); #1;
    bus.ack = 1'b0;
    chk("ack_rv", 32'(bus.result_valid), 0);
    chk("ack_err", 32'(bus.timeout_err), 0);
  endtask

  task automatic quiet();
    bus.wr_en = 1'b0; bus.core_finish = 1'b0; bus.ack = 1'b0;
  endtask

  // one run; pre=1 when start was left high and the run begins on the next edge
  task automatic run(input int wcyc, input bit fin, input int dec_in, input bit hold,
                     input bit pre, input bit same_wr, input int rst_at);
    logic [3:0] dec;
    logic [9:0] a;
    logic [7:0] d;
    int gaps;
    dec = (dec_in < 0) ? 4'($urandom_range(0, 14)) : 4'(dec_in);
    if (!pre) begin
      @(negedge clk);
      bus.start = 1'b1;
      if (same_wr) begin
        a = 10'($urandom_range(0, NPIX - 1)); d = 8'($urandom);
        bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
        model_mem[a] = d;
      end
    end
    for (int i = 0; i < NPIX; i++) exp_pix.push_back(model_mem[i]);
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
    if (!hold) bus.start = 1'b0;
    chk("core_rst_low", 32'(bus.core_rst_n), 0);
    chk("busy_set", 32'(bus.busy), 1);
    chk("rv_cleared", 32'(bus.result_valid), 0);
    @(posedge clk); #1;
    chk("core_rst_high", 32'(bus.core_rst_n), 1);
    chk("no_pix_in_rst", 32'(bus.pix_valid), 0);
    gaps = 0;
    for (int i = 0; i < NPIX; i++) begin
      bus.wr_en = 1'($urandom_range(0, 1));
      bus.wr_addr = (i == 10) ? 10'd5 : 10'($urandom_range(0, NPIX - 1));
      bus.wr_data = (i == 10) ? 8'hAA : 8'($urandom);
      if (i == 10) bus.wr_en = 1'b1;
      bus.core_finish = 1'($urandom_range(0, 1));
      bus.core_decision = 4'($urandom);
      bus.ack = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      if (!bus.pix_valid) gaps++;
      if (i == rst_at) begin
        quiet();
        #1 rst_n = 1'b0;
        #1;
        chk("arst_pix_valid", 32'(bus.pix_valid), 0);
        chk("arst_busy", 32'(bus.busy), 0);
        chk("arst_core_rst", 32'(bus.core_rst_n), 0);
        exp_pix.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        return;
      end
    end
    quiet();
    @(posedge clk); #1;
    chk("stream_gaps", 32'(gaps), 0);
    chk("stream_end_pv", 32'(bus.pix_valid), 0);
    chk("wait_busy", 32'(bus.busy), 1);
    bus.core_decision = 4'($urandom);
    if (fin) begin
      exp_res.push_back({1'b0, dec});
      repeat (wcyc) @(posedge clk);
      #1;
      bus.core_finish = 1'b1; bus.core_decision = dec;
      @(posedge clk); #1;
      bus.core_finish = 1'b0; bus.core_decision = 4'($urandom);
      chk("fin_busy", 32'(bus.busy), 0);
      chk("fin_err", 32'(bus.timeout_err), 0);
      chk("fin_result", 32'(bus.result), 32'(dec));
    end else begin
      exp_res.push_back({1'b1, 4'hF});
      repeat (TMO - 1) @(posedge clk);
      #1;
      chk("pre_expiry_busy", 32'(bus.busy), 1);
      @(posedge clk); #1;
      chk("tmo_busy", 32'(bus.busy), 0);
      chk("tmo_err", 32'(bus.timeout_err), 1);
      chk("tmo_result", 32'(bus.result), 32'hF);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0; bus.core_decision = '0; bus.wr_addr = '0; bus.wr_data = '0;
    quiet();
    #12;
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_core_rst", 32'(bus.core_rst_n), 0);
    chk("rst_pix_data", 32'(bus.pix_data), 0);
    chk("rst_pix_valid", 32'(bus.pix_valid), 0);
    chk("rst_result", 32'(bus.result), 0);
    chk("rst_rv", 32'(bus.result_valid), 0);
    chk("rst_err", 32'(bus.timeout_err), 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("core_rst_release", 32'(bus.core_rst_n), 1);

    load(1'b1);
    run(10, 1'b1, 2, 1'b0, 1'b0, 1'b0, -1);           // ramp frame, decision 2
    do_ack();
    run(0, 1'b0, -1, 1'b0, 1'b0, 1'b0, -1);           // timeout
    do_ack();
    run($urandom_range(0, 62), 1'b1, -1, 1'b0, 1'b0, 1'b0, -1);
    run(5, 1'b1, -1, 1'b0, 1'b0, 1'b0, 300);          // async reset mid-stream
    load(1'b0);
    run($urandom_range(0, 62), 1'b1, -1, 1'b0, 1'b0, 1'b0, -1);
    run(TMO - 1, 1'b1, -1, 1'b1, 1'b0, 1'b0, -1);     // start held, finish on expiry
    run($urandom_range(0, 62), 1'b1, -1, 1'b0, 1'b1, 1'b0, -1);
    for (int r = 0; r < 3; r++)
      run($urandom_range(0, 62), 1'($urandom_range(0, 1)), -1, 1'b0, 1'b0, 1'b1, -1);
    do_ack();

    repeat (4) @(posedge clk);
    #1;
    chk("pix_queue_empty", 32'(exp_pix.size()), 0);
    chk("res_queue_empty", 32'(exp_res.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
